nor_counter_sl: RTL and testbench

Parameterised synchronous up-counter built entirely at switch level from the two-input NOR cell (NorSL), so the whole block is NOR-only. It is the first sequential stage in the switch-level library: it consumes NOR gates as its only primitive and produces a registered count plus a terminal-count strobe for downstream switch-level or behavioural logic. Storage is a NOR-based master-slave D flip-flop per bit. Next-state logic is NOR-only ripple increment with enable and synchronous clear.

---
 rtl/nor_counter_sl.sv | 91 +++++++++
 tb/tb_nor_counter_sl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_counter_sl.sv
// nor_counter_sl: WIDTH-bit synchronous up-counter built only from NorSL cells.
// Ports: clk, reset (sync, active-high), en -> q (registered count), tc (comb).
//
// Per bit:
//   - carry  c[i+1] = c[i] & q[i]
//   - toggle t[i]   = q[i] ^ c[i]
//   - clear  d[i]   = t[i] & ~reset
// The toggle stays in XNOR form so the clear NOR takes ~t directly.
// Each bit is stored in a NOR master-slave flop.
// The master is gated by clk directly, so it shuts the instant clk rises.
// The slave opens only after clk_n falls, so there is no race through the pair.
module nor_counter_sl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   logic             w_clk_n;
   logic             w_en_n;
   logic             w_ctop_n;
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_c_n;
   logic [WIDTH-1:0] w_n1;
   logic [WIDTH-1:0] w_n2;
   logic [WIDTH-1:0] w_n3;
   logic [WIDTH-1:0] w_xnor;
   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] w_d_n;
   logic [WIDTH-1:0] w_sm;
   logic [WIDTH-1:0] w_rm;
   logic [WIDTH-1:0] w_m;
   logic [WIDTH-1:0] w_mb;
   logic [WIDTH-1:0] w_ss;
   logic [WIDTH-1:0] w_rs;
   logic [WIDTH-1:0] w_qb;

   NorSL u_clk_inv (.i_a(clk), .i_b(clk), .o_y(w_clk_n));

   // c[0] = en, buffered as two inverters so every carry node is a gate output.
   NorSL u_en_inv (.i_a(en),     .i_b(en),     .o_y(w_en_n));
   NorSL u_en_buf (.i_a(w_en_n), .i_b(w_en_n), .o_y(w_c[0]));

   // tc = c[WIDTH] & ~reset
   NorSL u_ctop_inv (.i_a(w_c[WIDTH]), .i_b(w_c[WIDTH]), .o_y(w_ctop_n));
   NorSL u_tc       (.i_a(w_ctop_n),   .i_b(reset),      .o_y(tc));

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      // Carry: NOR(~c, ~q). The slave's complement node serves as ~q.
      NorSL u_cn  (.i_a(w_c[i]),   .i_b(w_c[i]),  .o_y(w_c_n[i]));
      NorSL u_cy  (.i_a(w_c_n[i]), .i_b(w_qb[i]), .o_y(w_c[i+1]));

      // Four-NOR XNOR of q and c.
      NorSL u_x1  (.i_a(q[i]),     .i_b(w_c[i]),  .o_y(w_n1[i]));
      NorSL u_x2  (.i_a(q[i]),     .i_b(w_n1[i]), .o_y(w_n2[i]));
      NorSL u_x3  (.i_a(w_c[i]),   .i_b(w_n1[i]), .o_y(w_n3[i]));
      NorSL u_x4  (.i_a(w_n2[i]),  .i_b(w_n3[i]), .o_y(w_xnor[i]));

      // d = ~(~t | reset) = t & ~reset
      NorSL u_clr (.i_a(w_xnor[i]), .i_b(reset),  .o_y(w_d[i]));
      NorSL u_dn  (.i_a(w_d[i]),    .i_b(w_d[i]), .o_y(w_d_n[i]));

      // Master latch: set/reset are active only while clk=0.
      NorSL u_sm  (.i_a(w_d_n[i]), .i_b(clk),     .o_y(w_sm[i]));
      NorSL u_rm  (.i_a(w_d[i]),   .i_b(clk),     .o_y(w_rm[i]));
      NorSL u_m   (.i_a(w_rm[i]),  .i_b(w_mb[i]), .o_y(w_m[i]));
      NorSL u_mb  (.i_a(w_sm[i]),  .i_b(w_m[i]),  .o_y(w_mb[i]));

      // Slave latch: set/reset are active only while clk=1.
      NorSL u_ss  (.i_a(w_mb[i]),  .i_b(w_clk_n), .o_y(w_ss[i]));
      NorSL u_rs  (.i_a(w_m[i]),   .i_b(w_clk_n), .o_y(w_rs[i]));
      NorSL u_q   (.i_a(w_rs[i]),  .i_b(w_qb[i]), .o_y(q[i]));
      NorSL u_qb  (.i_a(w_ss[i]),  .i_b(q[i]),    .o_y(w_qb[i]));
   end

endmodule

// NorSL: two-input NOR cell, the only primitive used by the counter.
// Ports: i_a, i_b -> o_y = ~(i_a | i_b).
module NorSL (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);

   assign o_y = ~(i_a | i_b);

endmodule

// File: tb/tb_nor_counter_sl.sv
// tb_nor_counter_sl: scoreboard bench for nor_counter_sl at WIDTH 4, 1 and 8.
// Expected q/tc are pushed when stimulus is driven and popped when the DUT responds.
module tb_nor_counter_sl;

   logic       clk;
   logic       rst4, en4, rstw, enw;
   logic [3:0] q4;
   logic [0:0] q1;
   logic [7:0] q8;
   logic       tc4, tc1, tc8;

   int checks = 0;
   int errors = 0;

   logic [3:0] m4;
   logic [0:0] m1;
   logic [7:0] m8;

   logic [3:0] x4_q[$];
   logic       t4_q[$];
   logic [0:0] x1_q[$];
   logic       t1_q[$];
   logic [7:0] x8_q[$];
   logic       t8_q[$];

   logic [3:0] o_q4;
   logic [0:0] o_q1;
   logic [7:0] o_q8;
   logic       o_t4, o_t1, o_t8;

   nor_counter_sl #(.WIDTH(4)) u_w4 (
      .clk(clk), .reset(rst4), .en(en4), .q(q4), .tc(tc4));
   nor_counter_sl #(.WIDTH(1)) u_w1 (
      .clk(clk), .reset(rstw), .en(enw), .q(q1), .tc(tc1));
   nor_counter_sl #(.WIDTH(8)) u_w8 (
      .clk(clk), .reset(rstw), .en(enw), .q(q8), .tc(tc8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: still running at %0t, want finished", $time);
      $fatal(1, "timeout");
   end

   // One clock of the WIDTH=4 instance; called just after a falling edge.
   task automatic tick4(input logic r, input logic e);
      rst4 = r;
      en4  = e;
      #1;
      o_t4 = tc4;
      t4_q.push_back(e && !r && (m4 == 4'hF));
      m4 = r ? 4'd0 : (e ? m4 + 4'd1 : m4);
      x4_q.push_back(m4);
      @(posedge clk);
      #1;
      o_q4 = q4;
      @(negedge clk);
   endtask

   // One clock of the WIDTH=1 and WIDTH=8 pair.
   task automatic tickw(input logic r, input logic e);
      rstw = r;
      enw  = e;
      #1;
      o_t1 = tc1;
      o_t8 = tc8;
      t1_q.push_back(e && !r && (m1 == 1'b1));
      t8_q.push_back(e && !r && (m8 == 8'hFF));
      m1 = r ? 1'b0 : (e ? m1 + 1'b1 : m1);
      m8 = r ? 8'd0 : (e ? m8 + 8'd1 : m8);
      x1_q.push_back(m1);
      x8_q.push_back(m8);
      @(posedge clk);
      #1;
      o_q1 = q1;
      o_q8 = q8;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] eq;
      logic       et;
      for (int k = 0; k < 2; k++) begin
         tick4(1'b1, 1'b1);
         eq = x4_q.pop_front();
         et = t4_q.pop_front();
         checks += 2;
         if (o_q4 !== eq) begin
            errors++;
            $display("FAIL reset_q[%0d]: got %h want %h", k, o_q4, eq);
         end
         if (o_t4 !== et) begin
            errors++;
            $display("FAIL reset_tc[%0d]: got %b want %b", k, o_t4, et);
         end
      end
   endtask

   task automatic test_count_wrap();
      logic [3:0] eq;
      logic       et;
      int         hits = 0;
      for (int k = 0; k < 17; k++) begin
         tick4(1'b0, 1'b1);
         eq = x4_q.pop_front();
         et = t4_q.pop_front();
         if (o_t4 === 1'b1) hits++;
         checks += 2;
         if (o_q4 !== eq) begin
            errors++;
            $display("FAIL wrap_q[%0d]: got %0d want %0d", k, o_q4, eq);
         end
         if (o_t4 !== et) begin
            errors++;
            $display("FAIL wrap_tc[%0d]: got %b want %b", k, o_t4, et);
         end
      end
      checks++;
      if (hits != 1) begin
         errors++;
         $display("FAIL wrap_tc_count: got %0d want 1", hits);
      end
   endtask

   task automatic test_hold();
      logic [1:0] stim[$] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01,
                              2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
      logic [3:0] eq;
      logic       et;
      foreach (stim[k]) begin
         tick4(stim[k][1], stim[k][0]);
         eq = x4_q.pop_front();
         et = t4_q.pop_front();
         checks += 2;
         if (o_q4 !== eq) begin
            errors++;
            $display("FAIL hold_q[%0d]: got %0d want %0d", k, o_q4, eq);
         end
         if (o_t4 !== et) begin
            errors++;
            $display("FAIL hold_tc[%0d]: got %b want %b", k, o_t4, et);
         end
      end
      checks++;
      if (o_q4 !== 4'd6) begin
         errors++;
         $display("FAIL hold_final: got %0d want 6", o_q4);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] eq;
      logic       et;
      tick4(1'b1, 1'b0);
      for (int k = 0; k < 11; k++) begin
         if (k < 9)       tick4(1'b0, 1'b1);
         else if (k == 9) tick4(1'b1, 1'b1);
         else             tick4(1'b0, 1'b1);
      end
      void'(x4_q.pop_front());
      void'(t4_q.pop_front());
      for (int k = 0; k < 11; k++) begin
         eq = x4_q.pop_front();
         et = t4_q.pop_front();
         if (k < 9) continue;
         checks += 2;
         if (eq !== ((k == 9) ? 4'd0 : 4'd1)) begin
            errors++;
            $display("FAIL mid_model[%0d]: got %0d", k, eq);
         end
         if (et !== 1'b0) begin
            errors++;
            $display("FAIL mid_tc_model[%0d]: got %b want 0", k, et);
         end
      end
      checks++;
      if (o_q4 !== 4'd1) begin
         errors++;
         $display("FAIL mid_resume: got %0d want 1", o_q4);
      end
   endtask

   task automatic test_reset_tc();
      logic [3:0] eq;
      logic       et;
      tick4(1'b1, 1'b0);
      void'(x4_q.pop_front());
      void'(t4_q.pop_front());
      for (int k = 0; k < 15; k++) begin
         tick4(1'b0, 1'b1);
         void'(x4_q.pop_front());
         void'(t4_q.pop_front());
      end
      checks++;
      if (o_q4 !== 4'd15) begin
         errors++;
         $display("FAIL rtc_setup: got %0d want 15", o_q4);
      end
      tick4(1'b1, 1'b1);
      eq = x4_q.pop_front();
      et = t4_q.pop_front();
      checks += 2;
      if (o_t4 !== et) begin
         errors++;
         $display("FAIL rtc_tc: got %b want %b", o_t4, et);
      end
      if (o_q4 !== eq) begin
         errors++;
         $display("FAIL rtc_q: got %0d want %0d", o_q4, eq);
      end
   endtask

   task automatic test_width_sweep();
      logic [0:0] e1;
      logic [7:0] e8;
      logic       f1, f8;
      int         hits8 = 0;
      for (int k = 0; k < 258; k++) begin
         tickw(k == 0, 1'b1);
         e1 = x1_q.pop_front();
         f1 = t1_q.pop_front();
         e8 = x8_q.pop_front();
         f8 = t8_q.pop_front();
         if (o_t8 === 1'b1) hits8++;
         checks += 4;
         if (o_q1 !== e1) begin
            errors++;
            $display("FAIL w1_q[%0d]: got %b want %b", k, o_q1, e1);
         end
         if (o_t1 !== f1) begin
            errors++;
            $display("FAIL w1_tc[%0d]: got %b want %b", k, o_t1, f1);
         end
         if (o_q8 !== e8) begin
            errors++;
            $display("FAIL w8_q[%0d]: got %0d want %0d", k, o_q8, e8);
         end
         if (o_t8 !== f8) begin
            errors++;
            $display("FAIL w8_tc[%0d]: got %b want %b", k, o_t8, f8);
         end
      end
      checks++;
      if (hits8 != 1) begin
         errors++;
         $display("FAIL w8_tc_count: got %0d want 1", hits8);
      end
   endtask

   initial begin
      rst4 = 1'b0;
      en4  = 1'b0;
      rstw = 1'b0;
      enw  = 1'b0;
      m4   = 'x;
      m1   = 'x;
      m8   = 'x;
      @(negedge clk);
      test_reset();
      test_count_wrap();
      test_hold();
      test_reset_mid();
      test_reset_tc();
      test_width_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
